// File: rtl/issue_select.sv
// rtl/issue_select.sv - round-robin issue arbiter from the reservation station into the IS/EX stage
//
// Picks at most one eligible RS entry per cycle. The scan starts at rr_ptr and
// wraps. An entry is eligible when it is ready, its functional unit's writeback
// slot is free, and it does not depend on a branch that is being squashed.
//
// The winner goes to the tag buffer in the same cycle (grant, issue_valid,
// issued_*). It is registered into the IS/EX stage on the next edge (ex_*).
//
// Optional feature: define ISSUE_STARVE_GUARD_EN to add a saturating wait
// counter per entry. An eligible entry whose counter has reached STARVE_LIMIT
// overrides round-robin; the lowest such index wins.
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   stall                  freezes all state; suppresses issue
//   rs_ready/rs_is_mult    per-entry ready / needs-multiplier bits
//   rs_tag                 packed per-entry destination tags
//   rs_branch_mask         packed per-entry branch dependency masks
//   alu_can_issue          ALU writeback slot is free
//   mult_can_issue         multiplier writeback slot is free
//   squash, squash_mask    branch mispredict kill
//   grant                  one-hot winner (combinational)
//   issue_valid            issue request to tag buffer (combinational)
//   issued_tag             winner tag (combinational)
//   issued_branch_tag      winner branch mask (combinational)
//   issued_mult            winner is a multiply (combinational)
//   ex_*                   IS/EX pipeline register outputs

`ifndef RS_SIZE
`define RS_SIZE 8
`endif

module issue_select #(
    parameter int RS_SIZE      = `RS_SIZE,
    parameter int PHYS_REG_TAG = 6,
    parameter int BRANCH_MASK  = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int IDX_W       = $clog2(RS_SIZE)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            stall,
    input  logic [RS_SIZE-1:0]              rs_ready,
    input  logic [RS_SIZE-1:0]              rs_is_mult,
    input  logic [RS_SIZE*PHYS_REG_TAG-1:0] rs_tag,
    input  logic [RS_SIZE*BRANCH_MASK-1:0]  rs_branch_mask,
    input  logic                            alu_can_issue,
    input  logic                            mult_can_issue,
    input  logic                            squash,
    input  logic [BRANCH_MASK-1:0]          squash_mask,
    output logic [RS_SIZE-1:0]              grant,
    output logic                            issue_valid,
    output logic [PHYS_REG_TAG-1:0]         issued_tag,
    output logic [BRANCH_MASK-1:0]          issued_branch_tag,
    output logic                            issued_mult,
    output logic                            ex_valid,
    output logic [IDX_W-1:0]                ex_idx,
    output logic [PHYS_REG_TAG-1:0]         ex_tag,
    output logic [BRANCH_MASK-1:0]          ex_branch_mask,
    output logic                            ex_mult
);

    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    ex_valid_q, ex_valid_d;
    logic [IDX_W-1:0]        ex_idx_q, ex_idx_d;
    logic [PHYS_REG_TAG-1:0] ex_tag_q, ex_tag_d;
    logic [BRANCH_MASK-1:0]  ex_branch_mask_q, ex_branch_mask_d;
    logic                    ex_mult_q, ex_mult_d;

    logic [RS_SIZE-1:0]      eligible;
    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        scan_idx;

`ifdef ISSUE_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0]        wait_q [RS_SIZE];
    logic [CNT_W-1:0]        wait_d [RS_SIZE];
    logic                    starve_found;
    logic [IDX_W-1:0]        starve_idx;
`endif

    // Eligibility and winner selection
    always_comb begin
        eligible = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            eligible[i] = rs_ready[i]
                        & (rs_is_mult[i] ? mult_can_issue : alu_can_issue)
                        & ~(squash & |(rs_branch_mask[i*BRANCH_MASK +: BRANCH_MASK] & squash_mask));
        end

        // The index adder is IDX_W bits wide, so the scan wraps modulo RS_SIZE.
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            scan_idx = rr_ptr_q + IDX_W'(k);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end

`ifdef ISSUE_STARVE_GUARD_EN
        // The scan runs downward so the lowest starved index is the one kept.
        starve_found = 1'b0;
        starve_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (eligible[i] && (wait_q[i] == CNT_W'(STARVE_LIMIT))) begin
                starve_found = 1'b1;
                starve_idx   = IDX_W'(i);
            end
        end
        if (starve_found) begin
            winner = starve_idx;
        end
`endif
    end

    // Same-cycle issue request, gated by stall and reset
    always_comb begin
        grant             = '0;
        issue_valid       = 1'b0;
        issued_tag        = '0;
        issued_branch_tag = '0;
        issued_mult       = 1'b0;
        if (found && !stall && !reset) begin
            grant[winner]     = 1'b1;
            issue_valid       = 1'b1;
            issued_tag        = rs_tag[winner*PHYS_REG_TAG +: PHYS_REG_TAG];
            issued_branch_tag = rs_branch_mask[winner*BRANCH_MASK +: BRANCH_MASK];
            issued_mult       = rs_is_mult[winner];
        end
    end

    // Next state for the pointer and the IS/EX stage
    always_comb begin
        rr_ptr_d         = rr_ptr_q;
        ex_valid_d       = ex_valid_q;
        ex_idx_d         = ex_idx_q;
        ex_tag_d         = ex_tag_q;
        ex_branch_mask_d = ex_branch_mask_q;
        ex_mult_d        = ex_mult_q;

        if (issue_valid) begin
            rr_ptr_d = winner + IDX_W'(1);
        end

        if (!stall) begin
            ex_valid_d       = issue_valid;
            ex_idx_d         = issue_valid ? winner : '0;
            ex_tag_d         = issued_tag;
            ex_branch_mask_d = issued_branch_tag;
            ex_mult_d        = issued_mult;
        end

        // The kill is tested against the mask the stage holds after this edge.
        // A held entry can be killed. A freshly loaded winner has already
        // passed the squash filter, so it is never dropped by a stale entry.
        if (squash && |(ex_branch_mask_d & squash_mask)) begin
            ex_valid_d = 1'b0;
        end
    end

`ifdef ISSUE_STARVE_GUARD_EN
    // Wait counters: a grant or a not-ready entry clears the count;
    // otherwise the count climbs and saturates at STARVE_LIMIT.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wait_d[i] = wait_q[i];
            if (!stall) begin
                if (!rs_ready[i] || grant[i]) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] != CNT_W'(STARVE_LIMIT)) begin
                    wait_d[i] = wait_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (reset) begin
                wait_q[i] <= '0;
            end else begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q         <= '0;
            ex_valid_q       <= 1'b0;
            ex_idx_q         <= '0;
            ex_tag_q         <= '0;
            ex_branch_mask_q <= '0;
            ex_mult_q        <= 1'b0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            ex_valid_q       <= ex_valid_d;
            ex_idx_q         <= ex_idx_d;
            ex_tag_q         <= ex_tag_d;
            ex_branch_mask_q <= ex_branch_mask_d;
            ex_mult_q        <= ex_mult_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_idx         = ex_idx_q;
    assign ex_tag         = ex_tag_q;
    assign ex_branch_mask = ex_branch_mask_q;
    assign ex_mult        = ex_mult_q;

endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - directed self-checking bench for issue_select
`timescale 1ns/1ps

module tb_issue_select;

    localparam int N  = 8;
    localparam int TW = 6;
    localparam int BW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            stall;
    logic [N-1:0]    rs_ready;
    logic [N-1:0]    rs_is_mult;
    logic [N*TW-1:0] rs_tag;
    logic [N*BW-1:0] rs_branch_mask;
    logic            alu_can_issue;
    logic            mult_can_issue;
    logic            squash;
    logic [BW-1:0]   squash_mask;
    logic [N-1:0]    grant;
    logic            issue_valid;
    logic [TW-1:0]   issued_tag;
    logic [BW-1:0]   issued_branch_tag;
    logic            issued_mult;
    logic            ex_valid;
    logic [2:0]      ex_idx;
    logic [TW-1:0]   ex_tag;
    logic [BW-1:0]   ex_branch_mask;
    logic            ex_mult;

    int vectors = 0;
    int errors  = 0;

    issue_select #(
        .RS_SIZE      (N),
        .PHYS_REG_TAG (TW),
        .BRANCH_MASK  (BW),
        .STARVE_LIMIT (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .rs_ready          (rs_ready),
        .rs_is_mult        (rs_is_mult),
        .rs_tag            (rs_tag),
        .rs_branch_mask    (rs_branch_mask),
        .alu_can_issue     (alu_can_issue),
        .mult_can_issue    (mult_can_issue),
        .squash            (squash),
        .squash_mask       (squash_mask),
        .grant             (grant),
        .issue_valid       (issue_valid),
        .issued_tag        (issued_tag),
        .issued_branch_tag (issued_branch_tag),
        .issued_mult       (issued_mult),
        .ex_valid          (ex_valid),
        .ex_idx            (ex_idx),
        .ex_tag            (ex_tag),
        .ex_branch_mask    (ex_branch_mask),
        .ex_mult           (ex_mult)
    );

    always #5 clock = ~clock;

    // Entry i carries tag 40+i.
    function automatic logic [TW-1:0] tag_of(input int i);
        return TW'(40 + i);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rs_tag[i*TW +: TW] = tag_of(i);
        end
        rs_branch_mask = '0;
        rs_is_mult     = '0;
        reset          = 1'b1;
        stall          = 1'b0;
        rs_ready       = 8'hFF;
        alu_can_issue  = 1'b1;
        mult_can_issue = 1'b1;
        squash         = 1'b0;
        squash_mask    = '0;

        // Reset state: no issue while reset is high, and the stage is cleared
        tick();
        tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_issue_valid", 32'(issue_valid), 32'h0);
        chk("reset_ex_valid", 32'(ex_valid), 32'h0);
        chk("reset_ex_tag", 32'(ex_tag), 32'h0);
        reset    = 1'b0;
        rs_ready = 8'b0000_0101;
        #1;
        chk("first_grant", 32'(grant), 32'h01);
        chk("first_issued_tag", 32'(issued_tag), 32'(tag_of(0)));
        chk("first_issued_mult", 32'(issued_mult), 32'h0);
        tick();                                  // rr=1
        chk("first_ex_valid", 32'(ex_valid), 32'h1);
        chk("first_ex_idx", 32'(ex_idx), 32'h0);
        chk("first_ex_tag", 32'(ex_tag), 32'(tag_of(0)));
        rs_ready = 8'b0000_0100;
        #1;
        chk("second_grant", 32'(grant), 32'h04);
        tick();                                  // rr=3
        chk("second_ex_idx", 32'(ex_idx), 32'h2);

        // Move the pointer to 6, then check wrap-around
        rs_ready = 8'b0010_0000;
        #1;
        chk("to6_grant", 32'(grant), 32'h20);
        tick();                                  // rr=6
        rs_ready = 8'b0100_0010;
        #1;
        chk("wrap_a_grant", 32'(grant), 32'h40);
        tick();                                  // rr=7
        rs_ready = 8'b0000_0010;
        #1;
        chk("wrap_b_grant", 32'(grant), 32'h02);
        tick();                                  // rr=2
        chk("wrap_b_ex_idx", 32'(ex_idx), 32'h1);

        // No eligible entry: nothing issues, and the pointer holds at 2
        rs_ready = '0;
        #1;
        chk("idle_issue_valid", 32'(issue_valid), 32'h0);
        chk("idle_issued_tag", 32'(issued_tag), 32'h0);
        tick();
        chk("idle_ex_valid", 32'(ex_valid), 32'h0);
        chk("idle_ex_tag", 32'(ex_tag), 32'h0);
        rs_ready = 8'b1000_0000;
        #1;
        chk("to0_grant", 32'(grant), 32'h80);
        tick();                                  // rr=0

        // Structural hazard: the multiplier slot is busy
        rs_ready       = 8'b0000_0011;
        rs_is_mult     = 8'b0000_0001;
        mult_can_issue = 1'b0;
        #1;
        chk("struct_grant", 32'(grant), 32'h02);
        chk("struct_issued_mult", 32'(issued_mult), 32'h0);
        tick();                                  // rr=2
        rs_is_mult     = '0;
        mult_can_issue = 1'b1;

        // Squash filter: entry 2 depends on the squashed branch
        rs_branch_mask[2*BW +: BW] = 4'b0001;
        rs_branch_mask[3*BW +: BW] = 4'b0010;
        rs_ready    = 8'b0000_1100;
        squash      = 1'b1;
        squash_mask = 4'b0001;
        #1;
        chk("sqf_grant", 32'(grant), 32'h08);
        chk("sqf_issued_branch_tag", 32'(issued_branch_tag), 32'h2);
        tick();                                  // rr=4
        chk("sqf_ex_valid", 32'(ex_valid), 32'h1);
        chk("sqf_ex_branch_mask", 32'(ex_branch_mask), 32'h2);

        // Stall: no grant, and the stage holds
        squash   = 1'b0;
        stall    = 1'b1;
        rs_ready = 8'hFF;
        #1;
        chk("stall_grant", 32'(grant), 32'h0);
        chk("stall_issue_valid", 32'(issue_valid), 32'h0);
        tick();
        chk("stall_ex_valid_hold", 32'(ex_valid), 32'h1);
        chk("stall_ex_idx_hold", 32'(ex_idx), 32'h3);
        squash      = 1'b1;
        squash_mask = 4'b0010;
        tick();
        chk("stall_squash_ex_valid", 32'(ex_valid), 32'h0);
        chk("stall_squash_ex_idx", 32'(ex_idx), 32'h3);
        squash = 1'b0;
        stall  = 1'b0;
        rs_branch_mask = '0;
        #1;
        chk("post_stall_grant", 32'(grant), 32'h10);
        tick();                                  // rr=5

        // Multiply issue
        rs_ready   = 8'b0010_0000;
        rs_is_mult = 8'b0010_0000;
        #1;
        chk("mult_grant", 32'(grant), 32'h20);
        chk("mult_issued_mult", 32'(issued_mult), 32'h1);
        tick();                                  // rr=6
        chk("mult_ex_mult", 32'(ex_mult), 32'h1);
        chk("mult_ex_idx", 32'(ex_idx), 32'h5);
        rs_is_mult = '0;

        // Reset in the middle of operation
        rs_ready = 8'hFF;
        reset    = 1'b1;
        #1;
        chk("midreset_grant", 32'(grant), 32'h0);
        tick();
        chk("midreset_ex_valid", 32'(ex_valid), 32'h0);
        chk("midreset_ex_mult", 32'(ex_mult), 32'h0);
        reset = 1'b0;
        #1;
        chk("midreset_rr0_grant", 32'(grant), 32'h01);

        // Starvation: entries 0 and 5 wait four cycles behind a busy ALU
        rs_ready = 8'b0001_0000;
        #1;
        tick();                                  // rr=5
        rs_ready      = 8'b0010_0001;
        alu_can_issue = 1'b0;
        #1;
        chk("starve_blocked_grant", 32'(grant), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        alu_can_issue = 1'b1;
        #1;
`ifdef ISSUE_STARVE_GUARD_EN
        chk("starve_override_grant", 32'(grant), 32'h01);
        tick();                                  // rr=1
        rs_ready = 8'b0000_0011;
        #1;
        chk("starve_rr_after_grant", 32'(grant), 32'h02);
`else
        chk("starve_rr_grant", 32'(grant), 32'h20);
        tick();                                  // rr=6
        rs_ready = 8'b0000_0011;
        #1;
        chk("starve_rr_after_grant", 32'(grant), 32'h01);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Watchdog: the directed sequence is short, so a hang means a broken bench or DUT.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Per-cycle issue arbiter between the reservation station and the functional units.
- Picks at most one ready RS entry per cycle using rotating (round-robin) priority.
- Checks ALU/multiplier writeback-slot availability reported by the tag buffer, and drops entries being squashed.
- Drives the issue request to the tag buffer in the same cycle; registers the winner into the IS/EX pipeline stage.

Parameters:
- RS_SIZE, `RS_SIZE, number of RS entries arbitrated (power of 2, >=2).
- STARVE_LIMIT, 8, non-stalled wait cycles before an entry is forced to win (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes all state
- rs_ready  in  RS_SIZE  entry has operands ready and is valid
- rs_is_mult  in  RS_SIZE  entry needs the multiplier
- rs_tag  in  RS_SIZE x PHYS_REG_TAG  destination tag per entry
- rs_branch_mask  in  RS_SIZE x BRANCH_MASK  branch dependencies per entry
- alu_can_issue  in  1  tag buffer ALU slot free
- mult_can_issue  in  1  tag buffer mult slot free
- squash  in  1  branch mispredict squash valid
- squash_mask  in  BRANCH_MASK  branch being squashed
- grant  out  RS_SIZE  one-hot winner; RS frees that entry (combinational)
- issue_valid  out  1  issue request to tag buffer (combinational)
- issued_tag  out  PHYS_REG_TAG  winner tag (combinational)
- issued_branch_tag  out  BRANCH_MASK  winner branch mask (combinational)
- issued_mult  out  1  winner is a multiply (combinational)
- ex_valid  out  1  IS/EX register valid
- ex_idx  out  clog2(RS_SIZE)  IS/EX RS index
- ex_tag  out  PHYS_REG_TAG  IS/EX tag
- ex_branch_mask  out  BRANCH_MASK  IS/EX branch mask
- ex_mult  out  1  IS/EX multiply flag

Behaviour:
- Eligibility:
  - eligible[i] = rs_ready[i] & (rs_is_mult[i] ? mult_can_issue : alu_can_issue) & ~(squash & |(rs_branch_mask[i] & squash_mask)).
- Selection:
  - Scan from rr_ptr upward, wrapping modulo RS_SIZE; the first eligible index wins.
  - At most one grant bit is set.
  - No eligible entry -> grant=0 and issue_valid=0.
- Combinational outputs:
  - grant, issue_valid and issued_* are forced to 0 when stall=1 or reset=1.
  - issued_* are 0 whenever issue_valid=0.
- rr_ptr (clog2(RS_SIZE) bits):
  - Reset value 0.
  - On a clock edge with ~stall & issue_valid: rr_ptr <= winner+1, wrapping naturally (7+1 -> 0 for RS_SIZE=8).
  - Otherwise it holds.
- IS/EX register, on the clock edge:
  - Reset: all ex_* = 0.
  - ~stall: ex_valid <= issue_valid; ex_idx/tag/branch_mask/mult <= winner fields, or 0 when no issue.
  - stall: ex_* hold.
  - Squash priority: if squash & |(ex_branch_mask & squash_mask), ex_valid <= 0 at the edge, even under stall. Squash has priority over hold and over load; a newly loaded winner is already filtered by eligibility.
- Reset mid-operation: next edge clears rr_ptr, ex_* and starve counters; no grant while reset is high.
- Latency: grant in the same cycle as eligibility; ex_* valid one edge later.

Optional Feature:
- Macro: ISSUE_STARVE_GUARD_EN.
- Enabled:
  - Each entry has a saturating wait counter of clog2(STARVE_LIMIT+1) bits.
  - On a ~stall edge: cleared if rs_ready[i]=0 or entry i granted; otherwise incremented, saturating at STARVE_LIMIT.
  - Held under stall; reset to 0.
  - If any eligible entry has counter==STARVE_LIMIT, the lowest such index wins and overrides round-robin; rr_ptr still becomes winner+1.
- Disabled: pure round-robin; no counters are synthesized.

Test Plan:
- Reset, RS_SIZE=8, both can_issue=1, rs_ready=8'b0000_0101 -> grant=8'b0000_0001, rr_ptr=1. Next cycle rs_ready=8'b0000_0100 -> grant=8'b0000_0100, ex_idx=0, ex_valid=1.
- Wrap: rr_ptr=6, rs_ready=8'b0100_0010 -> grant idx 6, rr_ptr=7. Next cycle rs_ready=8'b0000_0010 -> grant idx 1, rr_ptr=2.
- Structural: rr_ptr=0, rs_ready=8'b0000_0011, rs_is_mult=8'b0000_0001, mult_can_issue=0, alu_can_issue=1 -> grant=8'b0000_0010, issued_mult=0.
- Stall: ex_valid=1, ex_branch_mask=4'b0010; stall=1, rs_ready=8'hFF -> grant=0, rr_ptr holds. Then squash=1, squash_mask=4'b0010 -> ex_valid=0 after the edge.
- Squash filter: rr_ptr=2, rs_ready=8'b0000_1100, entry 2 mask=4'b0001, squash=1, squash_mask=4'b0001 -> grant=8'b0000_1000.
- ISSUE_STARVE_GUARD_EN, STARVE_LIMIT=4: entry 0 ready, alu_can_issue=0 for 4 cycles, entry 5 ready; then alu_can_issue=1, rr_ptr=5 -> grant idx 0, rr_ptr=1.
